and3_arbiter: RTL and testbench

- Round-robin scheduler sharing one clocked and3 evaluation unit among NUM_REQ requesters.
- Each requester submits a 3-bit operand vector over a valid/ready handshake.
- The arbiter drives the shared and3 inputs, waits the unit's latency, samples o1, and returns a one-cycle result pulse to the winning requester.
- Sits between stimulus/transactor logic and an and3 instance in the and3 test tops.

---
 rtl/and3_arbiter_if.sv | 24 ++
 rtl/and3_arbiter.sv | 164 ++++++++++++++++
 tb/tb_and3_arbiter.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/and3_arbiter_if.sv
// Requester-side handshake bundle: request valid/ready/data plus result strobe.
// No logic, wiring only.
// req_ready comes from the arbiter combinationally; rsp_valid/rsp_data are a one-cycle strobe.
interface and3_arbiter_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [3*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ-1:0]   rsp_valid;
  logic                 rsp_data;

  // Requester / transactor side.
  modport master (
    output req_valid, req_data,
    input  req_ready, rsp_valid, rsp_data
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_data,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/and3_arbiter.sv
// Round-robin scheduler sharing one clocked and3 unit among NUM_REQ requesters; AND3_ARBITER_CHECK_EN adds a golden checker.
// Latency: result strobe DUT_LATENCY+2 cycles after the accept edge; one transaction per DUT_LATENCY+3 cycles.
// Backpressure: req_ready is offered (one-hot, combinational) only in IDLE; requesters hold valid/data until ready.
module and3_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int DUT_LATENCY = 1,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  and3_arbiter_if.slave     bus,
  output logic              dut_i1,
  output logic              dut_i2,
  output logic              dut_i3,
  input  logic              dut_o1,
  output logic              busy,
  output logic [CNT_W-1:0]  txn_count,
  output logic              chk_err
);

  localparam int IDW   = $clog2(NUM_REQ);
  localparam int LAT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [IDW-1:0]   rr_ptr_q;
  logic [IDW-1:0]   owner_q;
  logic [LAT_W-1:0] lat_cnt_q;
  logic             rsp_bit_q;

  logic             found;
  logic [IDW-1:0]   win_id;
  logic [2:0]       win_ops;
  logic             accept;
  logic             sample;
  int unsigned      idx;

  // Pick the first valid requester at or above rr_ptr, wrapping around.
  always_comb begin
    found   = 1'b0;
    win_id  = '0;
    win_ops = '0;
    idx     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(rr_ptr_q) + i) % NUM_REQ;
      if (!found && bus.req_valid[idx]) begin
        found   = 1'b1;
        win_id  = IDW'(idx);
        win_ops = bus.req_data[3*idx +: 3];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake outputs; ready is masked during reset so nothing looks accepted.
  always_comb begin
    state_d       = state_q;
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    bus.rsp_data  = 1'b0;
    busy          = (state_q != IDLE);
    accept        = 1'b0;
    sample        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found && reset_n) begin
          accept                = 1'b1;
          bus.req_ready[win_id] = 1'b1;
          state_d               = DRIVE;
        end
      end
      DRIVE: begin
        if (lat_cnt_q == '0) begin
          sample  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        bus.rsp_valid[owner_q] = 1'b1;
        bus.rsp_data           = rsp_bit_q;
        state_d                = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: operand drive, winner bookkeeping, latency countdown, result capture, counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dut_i1    <= 1'b0;
      dut_i2    <= 1'b0;
      dut_i3    <= 1'b0;
      rr_ptr_q  <= '0;
      owner_q   <= '0;
      lat_cnt_q <= '0;
      rsp_bit_q <= 1'b0;
      txn_count <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            dut_i1    <= win_ops[0];
            dut_i2    <= win_ops[1];
            dut_i3    <= win_ops[2];
            owner_q   <= win_id;
            lat_cnt_q <= LAT_W'(DUT_LATENCY);
            rr_ptr_q  <= (win_id == IDW'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
          end
        end
        DRIVE: begin
          if (lat_cnt_q != '0) begin
            lat_cnt_q <= lat_cnt_q - 1'b1;
          end
          if (sample) begin
            rsp_bit_q <= dut_o1;
          end
        end
        RESP: begin
          dut_i1    <= 1'b0;
          dut_i2    <= 1'b0;
          dut_i3    <= 1'b0;
          txn_count <= txn_count + 1'b1;
        end
        default: begin
          dut_i1 <= 1'b0;
          dut_i2 <= 1'b0;
          dut_i3 <= 1'b0;
        end
      endcase
    end
  end

`ifdef AND3_ARBITER_CHECK_EN
  logic golden;
  // Operands are held stable through DRIVE, so the live drive is the captured vector.
  assign golden = dut_i1 & dut_i2 & dut_i3;

  // Sticky flag: set on any sampled result that disagrees with the golden and3.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chk_err <= 1'b0;
    end else if (sample && (dut_o1 != golden)) begin
      chk_err <= 1'b1;
    end
  end
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_and3_arbiter.sv
// Directed bench for and3_arbiter with a one-stage and3 model and an output-forcing hook.
// Latency: checks the accept-to-strobe distance and round-robin grant spacing.
// Backpressure: requesters hold valid until they see ready, then drop or keep it as each case needs.
module tb_and3_arbiter;

  localparam int NR    = 2;
  localparam int LAT   = 1;
  localparam int CW    = 4;
`ifdef AND3_ARBITER_CHECK_EN
  localparam logic EXP_CHK = 1'b1;
`else
  localparam logic EXP_CHK = 1'b0;
`endif

  logic          clk;
  logic          reset_n;
  logic          dut_i1, dut_i2, dut_i3;
  logic          dut_o1;
  logic          busy;
  logic [CW-1:0] txn_count;
  logic          chk_err;
  logic          and_q;
  logic          force_zero;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_cnt = 0;
  int cyc     = 0;

  int            g_cyc[$];
  logic [NR-1:0] g_oh[$];
  int            r_cyc[$];
  logic [NR-1:0] r_oh[$];
  logic          r_dat[$];

  and3_arbiter_if #(.NUM_REQ(NR)) bus ();

  and3_arbiter #(.NUM_REQ(NR), .DUT_LATENCY(LAT), .CNT_W(CW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .dut_i1    (dut_i1),
    .dut_i2    (dut_i2),
    .dut_i3    (dut_i3),
    .dut_o1    (dut_o1),
    .busy      (busy),
    .txn_count (txn_count),
    .chk_err   (chk_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-stage and3 unit; force_zero pins its output low.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) and_q <= 1'b0;
    else          and_q <= dut_i1 & dut_i2 & dut_i3;
  end
  assign dut_o1 = force_zero ? 1'b0 : and_q;

  always @(posedge clk) cyc <= cyc + 1;

  // Log every grant and response seen mid-cycle.
  always @(negedge clk) begin
    if (bus.req_ready != '0) begin
      g_cyc.push_back(cyc);
      g_oh.push_back(bus.req_ready);
    end
    if (bus.rsp_valid != '0) begin
      r_cyc.push_back(cyc);
      r_oh.push_back(bus.rsp_valid);
      r_dat.push_back(bus.rsp_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One request from requester id with operands d; expects result exp_rsp 3 cycles after accept.
  task automatic run_txn(input int id, input logic [2:0] d, input logic exp_rsp);
    logic [NR-1:0] oh;
    int lat;
    logic got;
    oh = '0;
    oh[id] = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = oh;
    bus.req_data[3*id +: 3] = d;
    @(negedge clk);
    check("req_ready", bus.req_ready, oh);
    @(posedge clk); #1;
    bus.req_valid = '0;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 10) begin
      @(negedge clk);
      lat++;
      if (bus.rsp_valid != '0) got = 1'b1;
    end
    check("rsp_seen", got, 1);
    check("rsp_latency", lat, 3);
    check("rsp_valid", bus.rsp_valid, oh);
    check("rsp_data", bus.rsp_data, exp_rsp);
    exp_cnt = (exp_cnt + 1) % 16;
    @(negedge clk);
    check("txn_count", txn_count, exp_cnt);
    check("busy_after", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0, r0, base, bad;
    int exp_g[4];
    int exp_r[4];
    reset_n       = 1'b0;
    force_zero    = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    exp_g = '{1, 2, 1, 2};
    exp_r = '{1, 0, 1, 0};

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_dut_i", {dut_i3, dut_i2, dut_i1}, 0);
    check("rst_handshake", {bus.req_ready, bus.rsp_valid, bus.rsp_data}, 0);
    check("rst_count", txn_count, 0);
    check("rst_chk_err", chk_err, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Single request, all-ones operands.
    run_txn(0, 3'b111, 1'b1);

    // Abort in DRIVE: outputs drop at once, no response afterwards.
    @(posedge clk); #1;
    bus.req_valid = 2'b10;
    bus.req_data[5:3] = 3'b111;
    @(negedge clk);
    check("mid_ready", bus.req_ready, 2'b10);
    @(posedge clk); #1;
    bus.req_valid = '0;
    @(negedge clk);
    check("mid_busy", busy, 1);
    check("mid_drive", {dut_i3, dut_i2, dut_i1}, 3'b111);
    base = r_cyc.size();
    #1 reset_n = 1'b0;
    #1;
    check("abort_outs", {busy, dut_i3, dut_i2, dut_i1, bus.rsp_valid, bus.rsp_data}, 0);
    check("abort_count", txn_count, 0);
    exp_cnt = 0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    check("abort_no_rsp", r_cyc.size() - base, 0);

    // Round-robin with both requesters continuously valid.
    g0 = g_cyc.size();
    r0 = r_cyc.size();
    @(posedge clk); #1;
    bus.req_valid = 2'b11;
    bus.req_data  = {3'b011, 3'b111};
    repeat (16) @(posedge clk);
    #1 bus.req_valid = '0;
    @(negedge clk);
    check("rr_grants", g_cyc.size() - g0, 4);
    check("rr_rsps", r_cyc.size() - r0, 4);
    if (g_cyc.size() >= g0 + 4 && r_cyc.size() >= r0 + 4) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("rr_grant%0d", i), g_oh[g0+i], exp_g[i]);
        check($sformatf("rr_rsp_id%0d", i), r_oh[r0+i], exp_g[i]);
        check($sformatf("rr_rsp_dat%0d", i), r_dat[r0+i], exp_r[i]);
        check($sformatf("rr_rsp_lat%0d", i), r_cyc[r0+i] - g_cyc[g0+i], 3);
        if (i > 0) check($sformatf("rr_gap%0d", i), g_cyc[g0+i] - g_cyc[g0+i-1], 4);
      end
    end
    exp_cnt = exp_cnt + 4;
    check("rr_count", txn_count, exp_cnt);

    // 13 more transactions: 17 since reset wraps the 4-bit counter to 1.
    for (int i = 0; i < 13; i++) begin
      logic [2:0] d;
      d = 3'(i % 8);
      run_txn(i % 2, d, d == 3'b111);
    end
    check("wrap_count", txn_count, 1);

    // Faulty unit: result reports the unit's output, checker flags it and holds.
    force_zero = 1'b1;
    run_txn(0, 3'b111, 1'b0);
    check("chk_err_set", chk_err, EXP_CHK);
    force_zero = 1'b0;
    run_txn(1, 3'b111, 1'b1);
    check("chk_err_sticky", chk_err, EXP_CHK);

    // Quiet idle period.
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy || dut_i1 || dut_i2 || dut_i3 || (bus.req_ready != '0)) bad++;
    end
    check("idle_quiet", bad, 0);

    // Reset clears the sticky flag.
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check("chk_err_cleared", chk_err, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
